sol1_dma_arbiter: RTL and testbench



---
 rtl/sol1_dma_pkg.sv | 15 +
 rtl/sol1_rr_pick.sv | 33 +++
 rtl/sol1_dma_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sol1_dma_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sol1_dma_pkg.sv
// Shared types and default sizing for the Sol-1 DMA bus arbiter.
package sol1_dma_pkg;

    localparam int DMA_N_REQ      = 4;
    localparam int DMA_MAX_TENURE = 64;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GRANT,
        HANDOFF,
        RELEASE
    } dma_state_t;

endpackage

// File: rtl/sol1_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo N_REQ, wins.
module sol1_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any_req
);

    localparam int IW = $clog2(N_REQ);

    int            idx;
    logic [IW-1:0] pos;

    // Scan from the farthest offset back towards ptr so the nearest requester overwrites
    always_comb begin
        winner = '0;
        idx    = 0;
        pos    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            pos = idx[IW-1:0];
            if (req[pos]) begin
                winner = pos;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/sol1_dma_arbiter.sv
// sol1_dma_arbiter: parks the CPU through dma_req/dma_ack and hands the Sol-1
// system bus to DMA requesters one at a time in round-robin order.
// Optional feature macro: SOL1_DMA_TENURE_LIMIT_EN (preempts a grant after
// MAX_TENURE cycles when another requester is waiting).
module sol1_dma_arbiter
    import sol1_dma_pkg::*;
#(
    parameter int N_REQ      = DMA_N_REQ,
    parameter int MAX_TENURE = DMA_MAX_TENURE
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     cpu_dma_req,
    input  logic                     cpu_dma_ack,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_busy,
    output logic                     proto_err
);

    localparam int IW = $clog2(N_REQ);

    dma_state_t       state;
    dma_state_t       state_d;
    logic [IW-1:0]    cur;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    winner;
    logic [IW-1:0]    ptr_after;
    logic             any_req;
    logic             enter_grant;
    logic             violation;
    logic             others;
    logic [N_REQ-1:0] cur_onehot;
    logic [N_REQ-1:0] gnt_d;
    logic             cpu_dma_req_d;

    if (N_REQ < 2 || N_REQ > 8 || MAX_TENURE < 2) begin : g_param_check
        $error("sol1_dma_arbiter: unsupported N_REQ or MAX_TENURE");
    end

    sol1_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Decode the current grantee, competing requests and a CPU that let go of the bus early
    always_comb begin
        cur_onehot      = '0;
        cur_onehot[cur] = 1'b1;
        others          = |(req & ~cur_onehot);
        violation       = ((state == GRANT) || (state == HANDOFF)) && !cpu_dma_ack;
        ptr_after       = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end

`ifdef SOL1_DMA_TENURE_LIMIT_EN
    localparam int TW = $clog2(MAX_TENURE) + 1;

    logic [TW-1:0] tenure;
    logic          tenure_hit;

    assign tenure_hit = (tenure >= TW'(MAX_TENURE - 1));

    // Count cycles of the current grant, restarting at each new winner and saturating
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tenure <= '0;
        end else if (enter_grant) begin
            tenure <= '0;
        end else if ((state == GRANT) && (tenure != '1)) begin
            tenure <= tenure + 1'b1;
        end
    end
`endif

    // Next state plus the values the output registers will take on the coming edge
    always_comb begin
        state_d       = state;
        enter_grant   = 1'b0;
        gnt_d         = '0;
        cpu_dma_req_d = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_d = REQ;
            end
            REQ: begin
                cpu_dma_req_d = 1'b1;
                if (cpu_dma_ack) begin
                    if (any_req) begin
                        state_d     = GRANT;
                        enter_grant = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            GRANT: begin
                cpu_dma_req_d = !violation;
                gnt_d         = violation ? '0 : cur_onehot;
                if (violation) begin
                    state_d = RELEASE;
                end else if (!req[cur]) begin
                    state_d = others ? HANDOFF : RELEASE;
                end
`ifdef SOL1_DMA_TENURE_LIMIT_EN
                else if (tenure_hit && others) begin
                    state_d = HANDOFF;
                end
`endif
            end
            HANDOFF: begin
                cpu_dma_req_d = !violation;
                if (violation) begin
                    state_d = RELEASE;
                end else if (any_req) begin
                    state_d     = GRANT;
                    enter_grant = 1'b1;
                end else begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!cpu_dma_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, current grantee and round-robin pointer; the pointer moves past every winner
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            cur   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_d;
            if (enter_grant) begin
                cur <= winner;
                ptr <= ptr_after;
            end
        end
    end

    // Registered outputs so the bus sees glitch-free grant and handshake lines
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            gnt         <= '0;
            owner       <= '0;
            cpu_dma_req <= 1'b0;
            bus_busy    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            gnt         <= gnt_d;
            owner       <= cur;
            cpu_dma_req <= cpu_dma_req_d;
            bus_busy    <= cpu_dma_req_d | cpu_dma_ack;
            proto_err   <= violation;
        end
    end

endmodule

// File: tb/tb_sol1_dma_arbiter.sv
// Bench for sol1_dma_arbiter: directed scenarios plus random request bursts,
// with expected grant timelines computed from round-robin order and hold times.
// Honours SOL1_DMA_TENURE_LIMIT_EN for the preemption expectations.
module tb_sol1_dma_arbiter;

    localparam int N = 4;

    logic         clk         = 1'b0;
    logic         arst_n      = 1'b0;
    logic [N-1:0] req         = '0;
    logic         cpu_dma_ack = 1'b0;
    logic [N-1:0] gnt;
    logic         cpu_dma_req;
    logic [1:0]   owner;
    logic         bus_busy;
    logic         proto_err;

    int checks  = 0;
    int errors  = 0;
    int hold [N];
    int ptr_m   = 0;
    bit cpu_auto = 1'b1;
    int ack_cnt = 0;

    sol1_dma_arbiter #(
        .N_REQ      (N),
        .MAX_TENURE (8)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .req         (req),
        .gnt         (gnt),
        .cpu_dma_req (cpu_dma_req),
        .cpu_dma_ack (cpu_dma_ack),
        .owner       (owner),
        .bus_busy    (bus_busy),
        .proto_err   (proto_err)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the CPU acks after seeing dma_req on two samples and drops ack once dma_req falls
    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_auto) begin
            if (cpu_dma_req === 1'b1) begin
                ack_cnt++;
                if (ack_cnt >= 2) cpu_dma_ack = 1'b1;
            end else begin
                ack_cnt     = 0;
                cpu_dma_ack = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_output("idle_gnt", 32'(gnt), 32'(0));
        end
    endtask

    task automatic do_reset();
        arst_n      = 1'b0;
        req         = '0;
        cpu_dma_ack = 1'b0;
        ack_cnt     = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        ptr_m = 0;
    endtask

    // Raise all requesters in 'set' together from an idle bus; each drops after seeing its grant hold[w] times
    task automatic apply_stimulus(input logic [N-1:0] set);
        logic [N-1:0] exp_q [$];
        int           own_q [$];
        int           seen [N];
        int           last;
        int           total;
        logic [N-1:0] one;
        logic [N-1:0] bitw;
        logic [N-1:0] e;
        one  = {{(N-1){1'b0}}, 1'b1};
        last = ptr_m;
        for (int s = 0; s < 4; s++) begin
            exp_q.push_back('0);
            own_q.push_back(0);
        end
        for (int k = 0; k < N; k++) begin
            int w;
            w    = (ptr_m + k) % N;
            bitw = one << w;
            if ((set & bitw) != '0) begin
                for (int c = 0; c <= hold[w]; c++) begin
                    exp_q.push_back(bitw);
                    own_q.push_back(w);
                end
                exp_q.push_back('0);
                own_q.push_back(0);
                last = w;
            end
        end
        exp_q.push_back('0);
        own_q.push_back(0);
        total = exp_q.size();
        for (int w = 0; w < N; w++) seen[w] = 0;
        req = set;
        for (int s = 1; s <= total; s++) begin
            tick();
            e = exp_q[s-1];
            check_output($sformatf("gnt@%0d", s), 32'(gnt), 32'(e));
            check_output($sformatf("cpu_dma_req@%0d", s), 32'(cpu_dma_req), 32'(s >= 2 && s <= total - 2));
            check_output($sformatf("bus_busy@%0d", s), 32'(bus_busy), 32'(s >= 2 && s <= total - 1));
            check_output($sformatf("proto_err@%0d", s), 32'(proto_err), 32'(0));
            if (e != '0) check_output($sformatf("owner@%0d", s), 32'(owner), 32'(own_q[s-1]));
            for (int w = 0; w < N; w++) begin
                bitw = one << w;
                if ((gnt & bitw) != '0) begin
                    seen[w]++;
                    if (seen[w] == hold[w]) req = req & ~bitw;
                end
            end
        end
        req   = '0;
        ptr_m = (last + 1) % N;
    endtask

    initial begin
        logic [N-1:0] e;
        logic [N-1:0] set;
        $display("[TB] sol1_dma_arbiter bench starting");

        // Reset values while reset is held
        #12;
        check_output("rst_gnt", 32'(gnt), 32'(0));
        check_output("rst_cpu_dma_req", 32'(cpu_dma_req), 32'(0));
        check_output("rst_owner", 32'(owner), 32'(0));
        check_output("rst_bus_busy", 32'(bus_busy), 32'(0));
        check_output("rst_proto_err", 32'(proto_err), 32'(0));
        @(negedge clk);
        arst_n = 1'b1;
        idle_cycles(2);

        // Fairness: everyone requests from reset, grant order 0,1,2,3
        for (int w = 0; w < N; w++) hold[w] = 3;
        apply_stimulus(4'b1111);
        idle_cycles(2);

        // Single requester held for ten grant cycles
        hold[1] = 10;
        apply_stimulus(4'b0010);
        idle_cycles(2);

        // Handshake violation: CPU drops ack in the middle of a grant to requester 2
        req = 4'b0100;
        for (int s = 1; s <= 6; s++) begin
            tick();
            check_output($sformatf("viol_gnt@%0d", s), 32'(gnt), 32'((s >= 5) ? 4'b0100 : 4'b0000));
        end
        cpu_auto    = 1'b0;
        cpu_dma_ack = 1'b0;
        tick();
        check_output("viol_gnt_cleared", 32'(gnt), 32'(0));
        check_output("viol_proto_err", 32'(proto_err), 32'(1));
        check_output("viol_cpu_dma_req", 32'(cpu_dma_req), 32'(0));
        req = '0;
        tick();
        check_output("viol_proto_err_pulse", 32'(proto_err), 32'(0));
        check_output("viol_bus_busy", 32'(bus_busy), 32'(0));
        idle_cycles(3);
        ack_cnt  = 0;
        cpu_auto = 1'b1;
        ptr_m    = (2 + 1) % N;

        // Wrap-around: pointer sits at 3, so 3 wins before 0
        hold[0] = 2;
        hold[3] = 2;
        apply_stimulus(4'b1001);
        idle_cycles(2);

        // Random bursts
        for (int b = 0; b < 8; b++) begin
            set = 4'($urandom_range(1, 15));
            for (int w = 0; w < N; w++) hold[w] = $urandom_range(1, 4);
            apply_stimulus(set);
            idle_cycles(2);
        end

        // Reset mid-grant clears outputs without waiting for a clock edge
        req = 4'b0001;
        for (int s = 1; s <= 6; s++) tick();
        check_output("pre_rst_gnt", 32'(gnt), 32'(4'b0001));
        #2;
        arst_n = 1'b0;
        #1;
        check_output("async_rst_gnt", 32'(gnt), 32'(0));
        check_output("async_rst_cpu_dma_req", 32'(cpu_dma_req), 32'(0));
        check_output("async_rst_bus_busy", 32'(bus_busy), 32'(0));
        check_output("async_rst_owner", 32'(owner), 32'(0));
        do_reset();

        // Long grant to 0 with a competitor arriving on its second grant cycle
        req = 4'b0001;
        for (int s = 1; s <= 14; s++) begin
            tick();
`ifdef SOL1_DMA_TENURE_LIMIT_EN
            e = (s < 5) ? 4'b0000 : (s <= 12) ? 4'b0001 : (s == 13) ? 4'b0000 : 4'b0100;
`else
            e = (s < 5) ? 4'b0000 : 4'b0001;
`endif
            check_output($sformatf("tenure_gnt@%0d", s), 32'(gnt), 32'(e));
            if (s == 6) req = 4'b0101;
        end
        do_reset();

        // After reset the pointer is back at 0
        hold[0] = $urandom_range(1, 4);
        hold[3] = $urandom_range(1, 4);
        apply_stimulus(4'b1001);
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
